// File: rtl/drum_timing.sv
// Drum bit/word timing sequencer: counts bit times within a word and word times
// within a revolution, gating the upstream tick into phase strobes.
module drum_timing #(
    parameter int BITS  = 29,
    parameter int WORDS = 108
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     run,
    output logic                     bit_strobe,
    output logic                     t0,
    output logic                     t_last,
    output logic                     rev,
    output logic [$clog2(BITS)-1:0]  bit_num,
    output logic [$clog2(WORDS)-1:0] word_num,
    output logic                     running
);

    localparam int BW = $clog2(BITS);
    localparam int WW = $clog2(WORDS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUNNING  = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t state, state_next;
    logic   active;

    // Strobes are combinational on tick and describe the position held before the edge.
    // Reset also masks them so no strobe escapes while the sequencer is being cleared.
    always_comb begin
        active     = (state != STOPPED);
        bit_strobe = tick & active & ~rst;
        t0         = bit_strobe & (bit_num == '0);
        t_last     = bit_strobe & (bit_num == BIT_LAST);
        rev        = t_last & (word_num == WORD_LAST);
    end

    // NOTE: every branch starts from the hold value, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            STOPPED:  if (run) state_next = RUNNING;
            RUNNING:  if (!run) state_next = t_last ? STOPPED : STOPPING;
            STOPPING: begin
                if (t_last)   state_next = STOPPED;
                else if (run) state_next = RUNNING;
            end
            default:  state_next = STOPPED;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values seen before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STOPPED;
            running  <= 1'b0;
            bit_num  <= '0;
            word_num <= '0;
        end else begin
            state   <= state_next;
            running <= (state_next != STOPPED);
            if (bit_strobe) begin
                if (t_last) begin
                    bit_num  <= '0;
                    word_num <= (word_num == WORD_LAST) ? '0 : word_num + 1'b1;
                end else begin
                    bit_num <= bit_num + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_drum_timing.sv
// Scoreboard bench for drum_timing: stimulus queues expected strobes, a forked
// monitor pops and compares them on the falling edge whenever a strobe appears.
module tb_drum_timing;

    localparam int BITS  = 29;
    localparam int WORDS = 108;
    localparam int BW    = $clog2(BITS);
    localparam int WW    = $clog2(WORDS);

    logic          clk = 1'b0;
    logic          rst, tick, run;
    logic          bit_strobe, t0, t_last, rev, running;
    logic [BW-1:0] bit_num;
    logic [WW-1:0] word_num;

    drum_timing #(.BITS(BITS), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .tick(tick), .run(run),
        .bit_strobe(bit_strobe), .t0(t0), .t_last(t_last), .rev(rev),
        .bit_num(bit_num), .word_num(word_num), .running(running)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected strobe record: {rev, t_last, t0, word, bit}
    logic [31:0] sb[$];

    int n_strobe = 0, n_t0 = 0, n_tlast = 0, n_rev = 0;
    int last_rev_bit = -1, last_rev_word = -1, last_t0_word = -1;

    // Reference model: 0 stopped, 1 running, 2 stopping
    int m_state = 0, m_bit = 0, m_word = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic r, input logic tl, input logic z,
                                         input int w, input int b);
        return {17'd0, r, tl, z, 7'(w), 5'(b)};
    endfunction

    task automatic monitor();
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (bit_strobe) begin
                n_strobe++;
                if (t0) begin n_t0++; last_t0_word = int'(word_num); end
                if (t_last) n_tlast++;
                if (rev) begin
                    n_rev++;
                    last_rev_bit  = int'(bit_num);
                    last_rev_word = int'(word_num);
                end
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 32'(bit_strobe), 32'd0);
                end else begin
                    exp = sb.pop_front();
                    check("strobe", pack(rev, t_last, t0, int'(word_num), int'(bit_num)), exp);
                end
            end else begin
                check("stray_phase", {29'd0, t0, t_last, rev}, 32'd0);
                if (sb.size() != 0) begin
                    check("missing_strobe", 32'(sb.size()), 32'd0);
                    sb.delete();
                end
            end
        end
    endtask

    // One clock cycle with the given tick; run/rst are set by the caller.
    task automatic step(input logic tk);
        bit strobe, last;
        tick   = tk;
        strobe = tk && !rst && (m_state != 0);
        last   = strobe && (m_bit == BITS - 1);
        if (strobe)
            sb.push_back(pack(last && (m_word == WORDS - 1), last, m_bit == 0, m_word, m_bit));
        @(posedge clk);
        if (rst) begin
            m_state = 0; m_bit = 0; m_word = 0;
        end else begin
            if (strobe) begin
                m_bit = last ? 0 : m_bit + 1;
                if (last) m_word = (m_word == WORDS - 1) ? 0 : m_word + 1;
            end
            case (m_state)
                0: if (run) m_state = 1;
                1: if (!run) m_state = last ? 0 : 2;
                default: if (last) m_state = 0; else if (run) m_state = 1;
            endcase
        end
        #1;
        tick = 1'b0;
    endtask

    // n ticks, one every 4th cycle
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            for (int k = 0; k < 3; k++) step(1'b0);
        end
    endtask

    task automatic check_regs(input string name, input int b, input int w, input logic r);
        check({name, "_bit"}, 32'(bit_num), 32'(b));
        check({name, "_word"}, 32'(word_num), 32'(w));
        check({name, "_running"}, 32'(running), 32'(r));
    endtask

    int snap_strobe, snap_rev;

    initial begin
        rst = 1'b1; run = 1'b1; tick = 1'b1;
        fork monitor(); join_none
        @(posedge clk); #1;

        // Reset held with tick and run active
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check_regs("reset", 0, 0, 1'b0);
        end

        // Start: transition cycle, then count one word
        rst = 1'b0;
        step(1'b0);
        check("start_running", 32'(running), 32'd1);
        ticks(1);
        check("first_t0_word", 32'(last_t0_word), 32'd0);
        ticks(28);
        check_regs("word1", 0, 1, 1'b1);

        // Full revolution: 3132 ticks in total since start
        ticks(3132 - 29);
        check("rev_count", 32'(n_rev), 32'd1);
        check("rev_bit", 32'(last_rev_bit), 32'd28);
        check("rev_word", 32'(last_rev_word), 32'd107);
        check("t0_count", 32'(n_t0), 32'd108);
        check("tlast_count", 32'(n_tlast), 32'd108);
        check_regs("wrap", 0, 0, 1'b1);

        // Stop mid-word at word 5 bit 10
        ticks(5 * BITS + 10);
        check_regs("pre_stop", 10, 5, 1'b1);
        run = 1'b0;
        ticks(18);
        check_regs("stopping_t28", 28, 5, 1'b1);
        ticks(1);
        check_regs("stopped", 0, 6, 1'b0);
        snap_strobe = n_strobe;
        ticks(20);
        check("stopped_no_strobes", 32'(n_strobe - snap_strobe), 32'd0);
        check_regs("stopped_hold", 0, 6, 1'b0);

        // Restart with a simultaneous tick (ignored); next t0 is word 6
        run = 1'b1;
        step(1'b1);
        check_regs("restart", 0, 6, 1'b1);
        ticks(1);
        check("restart_t0_word", 32'(last_t0_word), 32'd6);

        // Cancel: drop run at bit 10, re-raise at bit 15
        ticks(9);
        check_regs("cancel_pre", 10, 6, 1'b1);
        snap_strobe = n_strobe;
        run = 1'b0;
        ticks(5);
        check_regs("cancel_mid", 15, 6, 1'b1);
        run = 1'b1;
        ticks(14);
        check_regs("cancel_done", 0, 7, 1'b1);
        check("cancel_no_gap", 32'(n_strobe - snap_strobe), 32'd19);

        // Drop run in the same cycle as t_last while RUNNING
        ticks(28);
        check_regs("tlast_pre", 28, 7, 1'b1);
        run = 1'b0;
        step(1'b1);
        check_regs("tlast_stop", 0, 8, 1'b0);

        // Mid-operation reset at bit 17 of word 40
        run = 1'b1;
        step(1'b0);
        ticks(32 * BITS + 17);
        check_regs("pre_reset", 17, 40, 1'b1);
        snap_rev = n_rev;
        rst = 1'b1;
        step(1'b0);
        check_regs("mid_reset", 0, 0, 1'b0);
        rst = 1'b0;
        run = 1'b0;
        ticks(3);
        check("reset_no_rev", 32'(n_rev - snap_rev), 32'd0);
        check_regs("post_reset", 0, 0, 1'b0);

        step(1'b0);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
